// File: rtl/prog_stream_loader.sv
// Boot-time program loader: turns a count-prefixed little-endian byte stream into
// imem line writes and dmem word writes, holding the core in reset until complete.
module prog_stream_loader #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned INSN_LEN    = 32,
    parameter int unsigned IMEM_LINES  = 512,
    parameter int unsigned DMEM_WORDS  = 4096,
    parameter logic [31:0] PAD_INSN    = 32'h13,
    localparam int unsigned ILA        = $clog2(IMEM_LINES),
    localparam int unsigned DWA        = $clog2(DMEM_WORDS),
    localparam int unsigned LW         = FETCH_WIDTH * INSN_LEN
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [7:0]     in_data,
    output logic           in_ready,
    output logic           imem_we,
    output logic [ILA-1:0] imem_addr,
    output logic [LW-1:0]  imem_wdata,
    output logic           dmem_we,
    output logic [DWA-1:0] dmem_addr,
    output logic [31:0]    dmem_wdata,
    output logic           loading,
    output logic           done,
    output logic           err
);

    localparam int unsigned SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [SW-1:0] SlotLast = SW'(FETCH_WIDTH - 1);
    localparam logic [31:0] IMaxWords = 32'(IMEM_LINES * FETCH_WIDTH);
    localparam logic [31:0] DMaxWords = 32'(DMEM_WORDS);

    typedef enum logic [2:0] {
        StIhdr, StIdata, StIflush, StDhdr, StDdata, StDone, StErr
    } state_e;

    state_e state_q, state_d;

    logic [1:0]     byte_cnt_q;
    logic [23:0]    word_q;      // low three bytes of the word being assembled
    logic [31:0]    count_q;     // N or M from the current header
    logic [31:0]    idx_q;       // words accepted since the header
    logic [SW-1:0]  slot_q;
    logic [LW-1:0]  line_q;
    logic           imem_we_q, dmem_we_q;
    logic [ILA-1:0] imem_addr_q;
    logic [DWA-1:0] dmem_addr_q;
    logic [LW-1:0]  imem_wdata_q;
    logic [31:0]    dmem_wdata_q;

    logic           accept, word_done, last_word;
    logic [31:0]    word_full;
    logic [LW-1:0]  line_ins, line_pad;

    assign accept    = in_valid && in_ready;
    assign word_done = accept && (byte_cnt_q == 2'd3);
    assign word_full = {in_data, word_q};
    assign last_word = (idx_q + 32'd1) == count_q;

    // Line assembly: earlier slots shift toward the MSBs; flush pads the empty tail
    always_comb begin
        line_ins = (line_q << INSN_LEN) | LW'(word_full);
        line_pad = line_q;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            if (i >= int'(slot_q)) line_pad = (line_pad << INSN_LEN) | LW'(PAD_INSN);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIhdr;
        else       state_q <= state_d;
    end

    // Next-state: header checks, end of each section, partial-line flush
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIhdr: if (word_done) begin
                if (word_full > IMaxWords)  state_d = StErr;
                else if (word_full == '0)   state_d = StDhdr;
                else                        state_d = StIdata;
            end
            StIdata: if (word_done && last_word) begin
                state_d = (slot_q == SlotLast) ? StDhdr : StIflush;
            end
            StIflush: state_d = StDhdr;
            StDhdr: if (word_done) begin
                if (word_full > DMaxWords)  state_d = StErr;
                else if (word_full == '0)   state_d = StDone;
                else                        state_d = StDdata;
            end
            StDdata: if (word_done && last_word) state_d = StDone;
            StDone:  state_d = StDone;
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    // FSM outputs; in_ready held low while reset is asserted
    always_comb begin
        in_ready = 1'b0;
        loading  = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            StIhdr, StIdata, StDhdr, StDdata: in_ready = !reset;
            StDone: begin
                loading = 1'b0;
                done    = 1'b1;
            end
            StErr:   err = 1'b1;
            default: ;
        endcase
    end

    // Datapath: byte assembly, counters, registered write strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q   <= '0;
            word_q       <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            slot_q       <= '0;
            line_q       <= '0;
            imem_we_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            dmem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_wdata_q <= '0;
        end else begin
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            if (imem_we_q) imem_addr_q <= imem_addr_q + ILA'(1);
            if (dmem_we_q) dmem_addr_q <= dmem_addr_q + DWA'(1);
            if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (byte_cnt_q != 2'd3) word_q[{byte_cnt_q, 3'b000} +: 8] <= in_data;
            end
            if (word_done) begin
                if (state_q == StIhdr || state_q == StDhdr) begin
                    count_q <= word_full;
                    idx_q   <= '0;
                    slot_q  <= '0;
                end else if (state_q == StIdata) begin
                    idx_q  <= idx_q + 32'd1;
                    line_q <= line_ins;
                    if (slot_q == SlotLast) begin
                        slot_q       <= '0;
                        imem_we_q    <= 1'b1;
                        imem_wdata_q <= line_ins;
                    end else begin
                        slot_q <= slot_q + SW'(1);
                    end
                end else if (state_q == StDdata) begin
                    idx_q        <= idx_q + 32'd1;
                    dmem_we_q    <= 1'b1;
                    dmem_wdata_q <= word_full;
                end
            end
            if (state_q == StIflush) begin
                imem_we_q    <= 1'b1;
                imem_wdata_q <= line_pad;
                slot_q       <= '0;
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_prog_stream_loader.sv
// Scoreboard bench for prog_stream_loader: a reference model turns each image into the
// expected imem/dmem write list; a negedge monitor pops and compares every strobe.
module tb_prog_stream_loader;

    localparam int FW = 4;
    localparam int LINES = 512;
    localparam int DWORDS = 4096;
    localparam int LW = FW * 32;
    localparam logic [31:0] PAD = 32'h13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready, imem_we, dmem_we, loading, done, err;
    logic [8:0]    imem_addr;
    logic [LW-1:0] imem_wdata;
    logic [11:0]   dmem_addr;
    logic [31:0]   dmem_wdata;

    prog_stream_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .loading    (loading),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [8:0] a; logic [LW-1:0] d; } iw_t;
    typedef struct packed { logic [11:0] a; logic [31:0] d; } dw_t;

    iw_t         iexp[$];
    dw_t         dexp[$];
    logic [31:0] insn[$];
    logic [31:0] dat[$];
    int          errors = 0;
    int          checks = 0;
    int          imem_cnt = 0;
    int          dmem_cnt = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of its expectation queue
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we && dmem_we) chk("both_strobes", 1, 0);
            if (imem_we) begin
                imem_cnt++;
                if (iexp.size() == 0) chk("imem_unexpected", 1, 0);
                else begin
                    iw_t e;
                    e = iexp.pop_front();
                    chk("imem_addr", LW'(imem_addr), LW'(e.a));
                    chk("imem_wdata", imem_wdata, e.d);
                end
            end
            if (dmem_we) begin
                dmem_cnt++;
                if (dexp.size() == 0) chk("dmem_unexpected", 1, 0);
                else begin
                    dw_t e;
                    e = dexp.pop_front();
                    chk("dmem_addr", LW'(dmem_addr), LW'(e.a));
                    chk("dmem_wdata", LW'(dmem_wdata), LW'(e.d));
                end
            end
        end
    end

    // Reference model: line l holds words 4l..4l+3, slot 0 in the MSBs, NOP past the end
    task automatic push_expected();
        int n;
        n = insn.size();
        for (int l = 0; l < (n + FW - 1) / FW; l++) begin
            iw_t e;
            e.a = 9'(l);
            e.d = '0;
            for (int s = 0; s < FW; s++)
                e.d[LW-1-32*s -: 32] = (l * FW + s < n) ? insn[l * FW + s] : PAD;
            iexp.push_back(e);
        end
        for (int i = 0; i < dat.size(); i++) begin
            dw_t e;
            e.a = 12'(i);
            e.d = dat[i];
            dexp.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit acc;
        acc = 0;
        while (int'($urandom_range(99)) < gap_pct) @(posedge clk) #1;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_pct);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap_pct);
    endtask

    task automatic apply_reset(input bit do_checks);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (do_checks) begin
            chk("rst_in_ready", LW'(in_ready), 0);
            chk("rst_loading", LW'(loading), 1);
            chk("rst_done", LW'(done), 0);
            chk("rst_err", LW'(err), 0);
            chk("rst_we", LW'({imem_we, dmem_we}), 0);
        end
        iexp.delete();
        dexp.delete();
        imem_cnt = 0;
        dmem_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic make_image(input int n, input int m);
        insn.delete();
        dat.delete();
        for (int i = 0; i < n; i++) insn.push_back($urandom);
        for (int i = 0; i < m; i++) dat.push_back($urandom);
    endtask

    // Sends the current image, waits for done and checks the end state
    task automatic run_image(input int gap_pct);
        bit seen;
        seen = 0;
        push_expected();
        send_word(32'(insn.size()), gap_pct);
        foreach (insn[i]) send_word(insn[i], gap_pct);
        send_word(32'(dat.size()), gap_pct);
        foreach (dat[i]) send_word(dat[i], gap_pct);
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = done;
        end
        @(negedge clk);
        chk("done", LW'(done), 1);
        chk("loading_end", LW'(loading), 0);
        chk("in_ready_end", LW'(in_ready), 0);
        chk("imem_strobes", LW'(imem_cnt), LW'((insn.size() + FW - 1) / FW));
        chk("dmem_strobes", LW'(dmem_cnt), LW'(dat.size()));
        chk("queues_empty", LW'(iexp.size() + dexp.size()), 0);
    endtask

    int cnt_gapless;

    initial begin
        apply_reset(1);
        @(negedge clk);
        chk("ready_after_reset", LW'(in_ready), 1);

        // Two full lines, two data words
        @(posedge clk) #1;
        make_image(8, 2);
        run_image(0);
        // Bytes after done are ignored
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("ignored_after_done", LW'(imem_cnt + dmem_cnt), 10'd4);

        // Partial last line padded from the flush state
        apply_reset(0);
        make_image(5, 3);
        run_image(0);

        // Empty image: done one cycle after the 8th byte
        apply_reset(0);
        make_image(0, 0);
        send_word(32'd0, 0);
        for (int b = 0; b < 3; b++) send_byte(8'h00, 0);
        chk("not_done_early", LW'(done), 0);
        send_byte(8'h00, 0);
        chk("empty_done", LW'(done), 1);
        chk("empty_loading", LW'(loading), 0);
        chk("empty_strobes", LW'(imem_cnt + dmem_cnt), 0);

        // imem capacity overflow
        apply_reset(0);
        send_word(32'(LINES * FW + 1), 0);
        @(negedge clk);
        chk("ovf_err", LW'(err), 1);
        chk("ovf_in_ready", LW'(in_ready), 0);
        chk("ovf_loading", LW'(loading), 1);
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("ovf_no_strobes", LW'(imem_cnt + dmem_cnt), 0);
        chk("ovf_err_sticky", LW'(err), 1);
        apply_reset(0);
        @(negedge clk);
        chk("err_cleared", LW'(err), 0);

        // dmem capacity overflow; exact-limit header is accepted
        @(posedge clk) #1;
        send_word(32'd0, 0);
        send_word(32'(DWORDS + 1), 0);
        @(negedge clk);
        chk("dovf_err", LW'(err), 1);
        apply_reset(0);
        send_word(32'd0, 0);
        send_word(32'(DWORDS), 0);
        @(negedge clk);
        chk("dmax_no_err", LW'({err, in_ready}), 1);

        // Same image gapless and with 50% gaps
        apply_reset(0);
        make_image(7, 5);
        run_image(0);
        cnt_gapless = imem_cnt + dmem_cnt;
        apply_reset(0);
        run_image(50);
        chk("gap_strobe_count", LW'(imem_cnt + dmem_cnt), LW'(cnt_gapless));

        // Reset after three data bytes, then a fresh image starting at line 0
        apply_reset(0);
        send_word(32'd4, 0);
        for (int b = 0; b < 3; b++) send_byte(8'($urandom), 0);
        apply_reset(0);
        make_image(4, 1);
        run_image(0);

        // Random images with random gaps
        for (int k = 0; k < 6; k++) begin
            apply_reset(0);
            make_image(int'($urandom_range(20)), int'($urandom_range(10)));
            run_image(int'($urandom_range(60)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
